regfile_wr_arbiter: RTL



---
 rtl/regfile_wr_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// The winning write is registered for one cycle; ZERO_REG writes handshake but never assert wr_en.
module regfile_wr_arbiter #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             last_grant
);

    localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

    logic             grant0;
    logic             grant1;
    logic             any_grant;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    logic             wr_en_q,      wr_en_d;
    logic [AW-1:0]    wr_addr_q,    wr_addr_d;
    logic [WIDTH-1:0] wr_data_q,    wr_data_d;
    logic             last_grant_q, last_grant_d;

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !hold) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign any_grant = grant0 | grant1;
    assign sel_addr  = grant1 ? req1_addr : req0_addr;
    assign sel_data  = grant1 ? req1_data : req0_data;

    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        if (any_grant) begin
            wr_en_d      = (sel_addr != ZeroAddr);
            wr_addr_d    = sel_addr;
            wr_data_d    = sel_data;
            last_grant_d = grant1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_grant_q;

endmodule
